// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Purpose:
//   This module is a word-addressed data memory behind a simple strobe
//   handshake with a fixed wait-state count. A request is accepted in IDLE
//   while the responder is armed and at least one strobe is low. Each accepted
//   request produces exactly one ready pulse, WAIT_CYCLES+1 clock edges after
//   acceptance, where the accepting edge counts as the first edge. Misaligned
//   requests, out-of-range requests and requests with both strobes low
//   complete with err=1 and Dataout=0. They leave the memory untouched.
//
// Parameters:
//   DEPTH        number of 32-bit words stored
//   WAIT_CYCLES  BUSY cycles between acceptance and completion (0..15)
//
// Ports:
//   clk        in   1  rising-edge clock
//   RST        in   1  asynchronous active-high reset
//   nRD        in   1  active-low read strobe
//   nWR        in   1  active-low write strobe
//   address    in  32  byte address of the access
//   writeData  in  32  write data
//   Dataout    out 32  registered read data, held until the next completion
//   ready      out  1  registered one-cycle completion pulse
//   err        out  1  registered one-cycle error pulse, coincident with ready
// -----------------------------------------------------------------------------
module data_mem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        nRD,
  input  logic        nWR,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] Dataout,
  output logic        ready,
  output logic        err
);

  // Word-index width; a one-word memory still needs a 1-bit index.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // First byte address past the end of the memory. It is 33 bits wide so that
  // the comparison cannot wrap for large DEPTH values.
  localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH);

  // The counter is loaded with WAIT_CYCLES-1. BUSY exits on the cycle where
  // the counter reads zero, so BUSY lasts exactly WAIT_CYCLES cycles.
  localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // ---------------------------------------------------------------------------
  // State and request registers
  // ---------------------------------------------------------------------------
  logic [1:0]    r_state;
  logic [1:0]    w_state_next;
  logic          r_armed;
  logic [3:0]    r_cnt;
  logic [3:0]    w_cnt_next;

  logic          r_op_rd;
  logic          r_op_wr;
  logic          r_op_err;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_wdata;

  logic [31:0]   r_dout;
  logic          r_ready;
  logic          r_err;

  // Storage. Contents are never reset.
  logic [31:0]   r_mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Request decode from the live inputs
  // ---------------------------------------------------------------------------
  logic          w_accept;
  logic          w_req_rd;
  logic          w_req_err;
  logic [AW-1:0] w_req_idx;

  assign w_accept  = (r_state == S_IDLE) && r_armed && (!nRD || !nWR);
  assign w_req_rd  = !nRD;
  assign w_req_idx = address[AW+1:2];
  assign w_req_err = (address[1:0] != 2'b00)
                  || ({1'b0, address} >= ADDR_LIMIT)
                  || (!nRD && !nWR);

  // ---------------------------------------------------------------------------
  // Completion attributes
  // When WAIT_CYCLES is 0, the DONE state is entered on the accepting edge
  // itself. The latched copies do not exist yet at that point, so the live
  // decode is used. Otherwise, the copies latched at acceptance are used.
  // ---------------------------------------------------------------------------
  logic          w_fin_rd;
  logic          w_fin_err;
  logic [AW-1:0] w_fin_idx;
  logic          w_enter_done;

  assign w_fin_rd     = w_accept ? w_req_rd  : r_op_rd;
  assign w_fin_err    = w_accept ? w_req_err : r_op_err;
  assign w_fin_idx    = w_accept ? w_req_idx : r_idx;
  assign w_enter_done = (w_state_next == S_DONE) && (r_state != S_DONE);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (WAIT_CYCLES == 0) begin
            w_state_next = S_DONE;
          end else begin
            w_state_next = S_BUSY;
            w_cnt_next   = WAIT_LOAD;
          end
        end
      end
      S_BUSY: begin
        if (r_cnt == 4'd0) begin
          w_state_next = S_DONE;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = 4'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control, request latch and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_armed  <= 1'b1;
      r_cnt    <= 4'd0;
      r_op_rd  <= 1'b0;
      r_op_wr  <= 1'b0;
      r_op_err <= 1'b0;
      r_idx    <= '0;
      r_wdata  <= 32'd0;
      r_dout   <= 32'd0;
      r_ready  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;

      // Snapshot the request. Input changes after this edge are ignored.
      if (w_accept) begin
        r_armed  <= 1'b0;
        r_op_rd  <= w_req_rd;
        r_op_wr  <= !nWR;
        r_op_err <= w_req_err;
        r_idx    <= w_req_idx;
        r_wdata  <= writeData;
      end

      // The responder re-arms only when both strobes are seen high. A strobe
      // held low across completion therefore cannot start a second access.
      // Acceptance needs a low strobe, so this assignment never conflicts
      // with the disarm above.
      if (nRD && nWR) begin
        r_armed <= 1'b1;
      end

      // ready and err are high exactly while the FSM sits in DONE.
      r_ready <= w_enter_done;
      r_err   <= w_enter_done && w_fin_err;

      // Dataout changes only on completion. An error clears it, a valid read
      // loads the addressed word, and a valid write leaves it untouched.
      if (w_enter_done) begin
        if (w_fin_err) begin
          r_dout <= 32'd0;
        end else if (w_fin_rd) begin
          r_dout <= r_mem[w_fin_idx];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Memory write port
  // The write happens on the edge that leaves DONE. A reset raised during BUSY
  // or DONE forces r_state back to IDLE asynchronously before that edge, so
  // an aborted write never reaches the array.
  // ---------------------------------------------------------------------------
  logic w_mem_we;

  assign w_mem_we = (r_state == S_DONE) && r_op_wr && !r_op_err;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  assign Dataout = r_dout;
  assign ready   = r_ready;
  assign err     = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//
// This is a directed testbench for data_mem_responder. Instance u_dut_w2 uses
// WAIT_CYCLES=2 and instance u_dut_w0 uses WAIT_CYCLES=0. Both instances share
// the clock and the reset. One set of stimulus signals is steered to the
// selected instance, and the other instance sees both strobes high.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

  logic        clk;
  logic        RST;
  logic        nRD;
  logic        nWR;
  logic [31:0] address;
  logic [31:0] writeData;
  logic        sel0;

  logic        a_nrd, a_nwr, b_nrd, b_nwr;
  logic [31:0] a_dout, b_dout, m_dout;
  logic        a_ready, b_ready, m_ready;
  logic        a_err, b_err, m_err;

  int n_checks = 0;
  int n_errors = 0;

  assign a_nrd   = sel0 ? 1'b1 : nRD;
  assign a_nwr   = sel0 ? 1'b1 : nWR;
  assign b_nrd   = sel0 ? nRD  : 1'b1;
  assign b_nwr   = sel0 ? nWR  : 1'b1;
  assign m_dout  = sel0 ? b_dout  : a_dout;
  assign m_ready = sel0 ? b_ready : a_ready;
  assign m_err   = sel0 ? b_err   : a_err;

  data_mem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) u_dut_w2 (
    .clk       (clk),
    .RST       (RST),
    .nRD       (a_nrd),
    .nWR       (a_nwr),
    .address   (address),
    .writeData (writeData),
    .Dataout   (a_dout),
    .ready     (a_ready),
    .err       (a_err)
  );

  data_mem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk       (clk),
    .RST       (RST),
    .nRD       (b_nrd),
    .nWR       (b_nwr),
    .address   (address),
    .writeData (writeData),
    .Dataout   (b_dout),
    .ready     (b_ready),
    .err       (b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one request for exactly one edge (the accepting edge, edge 1),
  // then drive junk onto the inputs. Count the edges until ready is seen.
  task automatic run_op(input string tag, input logic rd_n, input logic wr_n,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int exp_lat, input logic exp_err,
                        input logic [31:0] exp_data);
    int          lat;
    logic        got_err;
    logic [31:0] got_data;
    lat      = 0;
    got_err  = 1'b0;
    got_data = 32'd0;
    nRD = rd_n; nWR = wr_n; address = a; writeData = wd;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        nRD = 1'b1; nWR = 1'b1; address = 32'hFFFF_FFFF; writeData = 32'h0;
      end
      if (m_ready) begin
        lat      = i;
        got_err  = m_err;
        got_data = m_dout;
        break;
      end
    end
    $display("txn %s nRD=%b nWR=%b addr=%h wdata=%h -> lat=%0d err=%b dout=%h",
             tag, rd_n, wr_n, a, wd, lat, got_err, got_data);
    check_val({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    check_val({tag, ".err"}, {31'd0, got_err}, {31'd0, exp_err});
    check_val({tag, ".dout"}, got_data, exp_data);
    @(posedge clk); #1;
    check_val({tag, ".ready_clr"}, {31'd0, m_ready}, 32'd0);
    check_val({tag, ".err_clr"}, {31'd0, m_err}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;
    RST = 1'b1; nRD = 1'b1; nWR = 1'b1; address = 32'd0; writeData = 32'd0; sel0 = 1'b0;
    #3;
    check_val("rst.ready", {31'd0, a_ready}, 32'd0);
    check_val("rst.err", {31'd0, a_err}, 32'd0);
    check_val("rst.dout", a_dout, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    RST = 1'b0;

    // Write followed by a read of the same word.
    run_op("wr8",     1, 0, 32'h8,   32'hDEADBEEF, 3, 0, 32'h0);
    run_op("rd8",     0, 1, 32'h8,   32'h0,        3, 0, 32'hDEADBEEF);
    run_op("wr4",     1, 0, 32'h4,   32'hCAFEF00D, 3, 0, 32'hDEADBEEF);
    run_op("rd4",     0, 1, 32'h4,   32'h0,        3, 0, 32'hCAFEF00D);
    run_op("wrC",     1, 0, 32'hC,   32'h11112222, 3, 0, 32'hCAFEF00D);
    // Last word of the memory.
    run_op("wrFC",    1, 0, 32'hFC,  32'hA5A50001, 3, 0, 32'hCAFEF00D);
    run_op("rdFC",    0, 1, 32'hFC,  32'h0,        3, 0, 32'hA5A50001);
    // Both strobes low: the request errors and memory is unchanged.
    run_op("both4",   0, 0, 32'h4,   32'h1234,     3, 1, 32'h0);
    run_op("rd4b",    0, 1, 32'h4,   32'h0,        3, 0, 32'hCAFEF00D);
    // Misaligned address and out-of-range address.
    run_op("rd6",     0, 1, 32'h6,   32'h0,        3, 1, 32'h0);
    run_op("rd8b",    0, 1, 32'h8,   32'h0,        3, 0, 32'hDEADBEEF);
    run_op("rd100",   0, 1, 32'h100, 32'h0,        3, 1, 32'h0);
    // An out-of-range write must not alias onto word 0.
    run_op("wr100",   1, 0, 32'h100, 32'h77777777, 3, 1, 32'h0);
    run_op("rd8c",    0, 1, 32'h8,   32'h0,        3, 0, 32'hDEADBEEF);

    // A strobe held low gives exactly one completion.
    nRD = 1'b0; address = 32'h8;
    pulses = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (m_ready) pulses++;
    end
    $display("txn hold_rd addr=00000008 10 cycles -> pulses=%0d", pulses);
    check_val("hold.pulses", 32'(pulses), 32'd1);
    nRD = 1'b1;
    @(posedge clk); #1;
    check_val("hold.rearm_idle", {31'd0, m_ready}, 32'd0);
    nRD = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (m_ready) pulses++;
    end
    $display("txn rearm_rd addr=00000008 6 cycles -> pulses=%0d", pulses);
    check_val("rearm.pulses", 32'(pulses), 32'd1);
    check_val("rearm.dout", m_dout, 32'hDEADBEEF);
    nRD = 1'b1;
    @(posedge clk); @(posedge clk); #1;

    // A reset during BUSY aborts the write.
    nWR = 1'b0; address = 32'hC; writeData = 32'h55AA55AA;
    @(posedge clk); #1;
    nWR = 1'b1; address = 32'h0; writeData = 32'h0;
    #2;
    RST = 1'b1;
    #1;
    check_val("abort.ready", {31'd0, m_ready}, 32'd0);
    check_val("abort.err", {31'd0, m_err}, 32'd0);
    check_val("abort.dout", m_dout, 32'd0);
    // A strobe already low when reset releases is accepted on the first edge.
    nRD = 1'b0; address = 32'hC;
    pulses = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (m_ready) pulses++;
    end
    check_val("abort.no_pulse", 32'(pulses), 32'd0);
    RST = 1'b0;
    $display("txn abort_wrC wdata=55aa55aa reset in BUSY");
    run_op("rdC_rst", 0, 1, 32'hC, 32'h0, 3, 0, 32'h11112222);

    // WAIT_CYCLES=0 instance.
    sel0 = 1'b1;
    #1;
    check_val("w0.idle_dout", m_dout, 32'd0);
    run_op("w0_wr0",  1, 0, 32'h0,   32'h0BADC0DE, 1, 0, 32'h0);
    run_op("w0_rd0",  0, 1, 32'h0,   32'h0,        1, 0, 32'h0BADC0DE);
    run_op("w0_rd100",0, 1, 32'h100, 32'h0,        1, 1, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
